fourbytemerge: RTL and testbench
================================

# fourbytemerge

Streaming merge stage directly downstream of the two-byte sorter pairs in the mergesort datapath. Accepts two ascending-sorted pairs (the registered left/right outputs of two upstream two-byte sorters) in one handshake, merges them with two read pointers, and emits the four bytes in ascending order, one byte per cycle, under a valid/ready handshake with a last marker. Its output feeds the next merge level, which consumes 4-byte sorted runs.

## Interface
- WIDTH, 8, bit width of each element
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  a0/a1/b0/b1 hold a valid group
- in_ready  output  1  block accepts a group this cycle
- a0, a1  input  WIDTH  run A, ascending (a0 <= a1)
- b0, b1  input  WIDTH  run B, ascending (b0 <= b1)
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts out_data
- out_data  output  WIDTH  merged element, unsigned
- out_last  output  1  high with the 4th element of a group
- order_err  output  1  sticky: an accepted group violated a0<=a1 or b0<=b1

## Operation
- States: IDLE, MERGE.
- IDLE: in_ready=1, out_valid=0, out_data=0, out_last=0.
- Accept = in_valid & in_ready: latch A[0..1]=a0,a1 and B[0..1]=b0,b1; ia=0, ib=0, cnt=0; go MERGE.
- MERGE: out_valid=1. Selection, unsigned compare:
  - ia==2 -> B[ib], ib advances
  - ib==2 -> A[ia], ia advances
  - otherwise A[ia] <= B[ib] -> A[ia] (ties take A, stable), else B[ib]
- Pointer/cnt advance only on out_valid & out_ready. out_data and out_last hold stable while out_ready=0.
- out_last = (cnt==3) in MERGE.
- Last beat taken (out_last & out_ready):
  - in_ready=1 in that same cycle (combinational from out_ready).
  - If in_valid, the new group is latched, pointers cleared, state stays MERGE.
  - Else state goes to IDLE.
- in_ready=0 in MERGE except on the last beat with out_ready=1.
- order_err is set on accept if a0>a1 or b0>b1 and stays set until reset. The group is still merged, with no correction.
- Pointers are 2 bits wide (values 0..2). cnt is 2 bits.

## Timing
- Reset (async assert, sync release): state=IDLE, A, B, ia, ib, cnt all 0, order_err=0. Outputs are then in_ready=1, out_valid=0, out_data=0, out_last=0.
- Latency: first element has out_valid=1 the cycle after accept.
- Throughput: 4 cycles per group with back-to-back input and out_ready held at 1. A group with no queued successor costs 1 extra IDLE cycle.
- Backpressure: while out_ready=0 nothing advances and no input is accepted.
- Reset asserted mid-group: the partial group is discarded and outputs drop to reset values immediately.

## Structure
- The shared package holds the `WIDTH` default, the state encoding (IDLE=0, MERGE=1), and the group-size constant of 4, reused by later merge levels.
- A natural sub-module is `mergeselect`: combinational pointer/compare select returning the element and which side advances. It is reusable in wider merge stages.
- Everything else (FSM, buffers, counters, handshake) stays in `fourbytemerge`.

## Test plan
- Reset mid-MERGE: assert reset at beat 2 -> out_valid=0, in_ready=1, order_err=0 immediately. After release the next group merges correctly from beat 0.
- Interleaved runs: A=(1,5), B=(3,9), out_ready=1 -> out 1,3,5,9 on consecutive cycles, with out_last on 9, then in_ready=1.
- One run exhausted first, with ties: A=(2,2), B=(2,7) -> 2(A),2(A),2(B),7. Then A=(10,20), B=(1,4) -> 1,4,10,20.
- Backpressure: A=(0,255), B=(128,128), out_ready toggled 1,0,0,1,1,0,1 -> sequence 0,128,128,255. out_data and out_last are held during stalls, and in_ready stays 0 until the last beat is taken.
- Back-to-back groups: in_valid held with 3 groups and out_ready=1 -> 12 outputs in 12 consecutive cycles, with out_last every 4th and no IDLE gap.
- Order error: A=(9,3), B=(1,2) -> order_err=1 the cycle after accept and stays set. Output is 1,2,9,3.

Source files
------------

// File: rtl/fourbytemerge_pkg.sv
// Shared definitions for the mergesort merge levels.
//   WIDTH_DEFAULT : default element width
//   GROUP_SIZE    : elements per merged group at the 4-byte level
//   state_t       : merge-stage FSM encoding (IDLE=0, MERGE=1)
package fourbytemerge_pkg;

    localparam int WIDTH_DEFAULT = 8;
    localparam int GROUP_SIZE    = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } state_t;

endpackage

// File: rtl/fourbytemerge_mergeselect.sv
// Two-pointer merge select: picks the next element of two ascending
// two-element runs and reports which side advances.
//   a0, a1, b0, b1 : run contents
//   ia, ib         : read pointers (0..2, 2 = run exhausted)
//   data           : selected element
//   take_a         : 1 when the element comes from run A
module mergeselect
    import fourbytemerge_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] b1,
    input  logic [1:0]       ia,
    input  logic [1:0]       ib,
    output logic [WIDTH-1:0] data,
    output logic             take_a
);

    logic [WIDTH-1:0] a_cur;
    logic [WIDTH-1:0] b_cur;

    // Pointer bit 0 selects the element; an exhausted pointer (2) is
    // filtered out by the take_a decision below.
    assign a_cur = ia[0] ? a1 : a0;
    assign b_cur = ib[0] ? b1 : b0;

    always_comb begin
        take_a = 1'b0;
        if (ib == 2'd2) begin
            take_a = 1'b1;
        end else if (ia == 2'd2) begin
            take_a = 1'b0;
        end else begin
            // Ties go to A so equal keys keep their original order.
            take_a = (a_cur <= b_cur);
        end
    end

    assign data = take_a ? a_cur : b_cur;

endmodule

// File: rtl/fourbytemerge.sv
// Merge stage for two ascending two-element runs. Accepts one group of
// four bytes per input handshake and emits them in ascending order, one
// per cycle, flagging the fourth with out_last.
//   clock, reset          : clock, asynchronous active-low reset
//   in_valid / in_ready   : input group handshake
//   a0, a1 / b0, b1       : run A / run B, each expected ascending
//   out_valid / out_ready : output element handshake
//   out_data, out_last    : merged element, end-of-group marker
//   order_err             : sticky flag, an accepted run was not ascending
module fourbytemerge
    import fourbytemerge_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] b1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             order_err
);

    localparam logic [1:0] LAST_CNT = 2'(GROUP_SIZE - 1);

    state_t           state_reg;
    logic [WIDTH-1:0] a0_reg, a1_reg, b0_reg, b1_reg;
    logic [1:0]       ia_reg, ib_reg, cnt_reg;
    logic             order_err_reg;

    logic [WIDTH-1:0] sel_data;
    logic             sel_take_a;
    logic             in_merge;
    logic             accept;
    logic             beat;

    mergeselect #(.WIDTH(WIDTH)) u_select (
        .a0     (a0_reg),
        .a1     (a1_reg),
        .b0     (b0_reg),
        .b1     (b1_reg),
        .ia     (ia_reg),
        .ib     (ib_reg),
        .data   (sel_data),
        .take_a (sel_take_a)
    );

    assign in_merge  = (state_reg == MERGE);
    assign out_valid = in_merge;
    assign out_last  = in_merge && (cnt_reg == LAST_CNT);
    // Outputs come straight from held registers, so they stay stable
    // during stalls and fall to zero as soon as reset asserts.
    assign out_data  = in_merge ? sel_data : '0;
    assign order_err = order_err_reg;

    // A new group can slip in on the same cycle the last beat leaves,
    // which gives gap-free back-to-back groups.
    assign in_ready = !in_merge || (out_last && out_ready);
    assign accept   = in_valid && in_ready;
    assign beat     = out_valid && out_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            a0_reg        <= '0;
            a1_reg        <= '0;
            b0_reg        <= '0;
            b1_reg        <= '0;
            ia_reg        <= 2'd0;
            ib_reg        <= 2'd0;
            cnt_reg       <= 2'd0;
            order_err_reg <= 1'b0;
        end else if (accept) begin
            state_reg <= MERGE;
            a0_reg    <= a0;
            a1_reg    <= a1;
            b0_reg    <= b0;
            b1_reg    <= b1;
            ia_reg    <= 2'd0;
            ib_reg    <= 2'd0;
            cnt_reg   <= 2'd0;
            // Unsorted runs are merged as-is; only the flag records it.
            if ((a0 > a1) || (b0 > b1)) begin
                order_err_reg <= 1'b1;
            end
        end else if (beat) begin
            if (out_last) begin
                state_reg <= IDLE;
            end else begin
                cnt_reg <= cnt_reg + 2'd1;
                if (sel_take_a) begin
                    ia_reg <= ia_reg + 2'd1;
                end else begin
                    ib_reg <= ib_reg + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fourbytemerge.sv
module tb_fourbytemerge;

    logic       clock;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a0, a1, b0, b1;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       order_err;

    int checks;
    int errors;

    fourbytemerge #(.WIDTH(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a0        (a0),
        .a1        (a1),
        .b0        (b0),
        .b1        (b1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .order_err (order_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Timing discipline: every task starts and ends 1 time unit after a
    // rising edge; inputs change there and outputs are sampled 1 unit later.

    task automatic test_reset();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'd0 ||
            out_last !== 1'b0 || order_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: in_ready=%b out_valid=%b out_data=%0d out_last=%b order_err=%b, expected 1 0 0 0 0",
                     in_ready, out_valid, out_data, out_last, order_err);
        end
        $display("reset: in_ready=%b out_valid=%b out_data=%0d", in_ready, out_valid, out_data);
    endtask

    // One group with out_ready held high, followed by the single IDLE cycle.
    task automatic test_group(input string name, input logic [7:0] x0, input logic [7:0] x1,
                              input logic [7:0] y0, input logic [7:0] y1, input logic [31:0] expv);
        logic [7:0] e;
        in_valid = 1'b1; a0 = x0; a1 = x1; b0 = y0; b1 = y1; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_accept_ready: in_ready=%b expected 1", name, in_ready);
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            e = expv[31-8*k -: 8];
            checks++;
            if (out_valid !== 1'b1 || out_data !== e || out_last !== (k == 3) || in_ready !== (k == 3)) begin
                errors++;
                $display("FAIL %s_beat%0d: valid=%b data=%0d last=%b in_ready=%b, expected 1 %0d %b %b",
                         name, k, out_valid, out_data, out_last, in_ready, e, k == 3, k == 3);
            end
            $display("%s beat %0d: data=%0d last=%b", name, k, out_data, out_last);
            @(posedge clock); #1;
        end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_idle: out_valid=%b in_ready=%b, expected 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_interleave();
        test_group("interleave", 8'd1, 8'd5, 8'd3, 8'd9, {8'd1, 8'd3, 8'd5, 8'd9});
    endtask

    task automatic test_ties();
        test_group("ties", 8'd2, 8'd2, 8'd2, 8'd7, {8'd2, 8'd2, 8'd2, 8'd7});
        test_group("b_first", 8'd10, 8'd20, 8'd1, 8'd4, {8'd1, 8'd4, 8'd10, 8'd20});
    endtask

    task automatic test_backpressure();
        logic       rdy [7];
        logic [7:0] ed  [7];
        logic       el  [7];
        logic       er  [7];
        rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        ed  = '{8'd0, 8'd128, 8'd128, 8'd128, 8'd128, 8'd255, 8'd255};
        el  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        er  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        in_valid = 1'b1; a0 = 8'd0; a1 = 8'd255; b0 = 8'd128; b1 = 8'd128; out_ready = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 7; c++) begin
            out_ready = rdy[c];
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== ed[c] || out_last !== el[c] || in_ready !== er[c]) begin
                errors++;
                $display("FAIL bp_cycle%0d: valid=%b data=%0d last=%b in_ready=%b, expected 1 %0d %b %b",
                         c, out_valid, out_data, out_last, in_ready, ed[c], el[c], er[c]);
            end
            $display("backpressure cycle %0d: ready=%b data=%0d last=%b", c, rdy[c], out_data, out_last);
            @(posedge clock); #1;
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_idle: out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ga0 [3];
        logic [7:0] ga1 [3];
        logic [7:0] gb0 [3];
        logic [7:0] gb1 [3];
        logic [7:0] ex  [12];
        int g;
        ga0 = '{8'd1, 8'd8, 8'd20};
        ga1 = '{8'd2, 8'd9, 8'd40};
        gb0 = '{8'd3, 8'd5, 8'd30};
        gb1 = '{8'd4, 8'd6, 8'd50};
        ex  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd20, 8'd30, 8'd40, 8'd50};
        out_ready = 1'b1;
        in_valid = 1'b1; a0 = ga0[0]; a1 = ga1[0]; b0 = gb0[0]; b1 = gb1[0];
        @(posedge clock);
        for (int c = 0; c < 12; c++) begin
            #1;
            g = c / 4 + 1;
            if (g < 3) begin
                in_valid = 1'b1; a0 = ga0[g]; a1 = ga1[g]; b0 = gb0[g]; b1 = gb1[g];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== ex[c] || out_last !== (c % 4 == 3) ||
                in_ready !== (c % 4 == 3)) begin
                errors++;
                $display("FAIL b2b_out%0d: valid=%b data=%0d last=%b in_ready=%b, expected 1 %0d %b %b",
                         c, out_valid, out_data, out_last, in_ready, ex[c], c % 4 == 3, c % 4 == 3);
            end
            $display("back_to_back out %0d: data=%0d last=%b", c, out_data, out_last);
            @(posedge clock);
        end
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_order_err();
        checks++;
        if (order_err !== 1'b0) begin
            errors++;
            $display("FAIL order_err_before: order_err=%b expected 0", order_err);
        end
        test_group("order_err", 8'd9, 8'd3, 8'd1, 8'd2, {8'd1, 8'd2, 8'd9, 8'd3});
        checks++;
        if (order_err !== 1'b1) begin
            errors++;
            $display("FAIL order_err_sticky: order_err=%b expected 1", order_err);
        end
        $display("order_err after group: %b", order_err);
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; a0 = 8'd4; a1 = 8'd6; b0 = 8'd5; b1 = 8'd7; out_ready = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'd6) begin
            errors++;
            $display("FAIL mid_beat2: valid=%b data=%0d, expected 1 6", out_valid, out_data);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || order_err !== 1'b0 ||
            out_data !== 8'd0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b in_ready=%b order_err=%b data=%0d last=%b, expected 0 1 0 0 0",
                     out_valid, in_ready, order_err, out_data, out_last);
        end
        $display("reset mid-group: out_valid=%b in_ready=%b order_err=%b", out_valid, in_ready, order_err);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        test_group("after_reset", 8'd3, 8'd8, 8'd2, 8'd9, {8'd2, 8'd3, 8'd8, 8'd9});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a0 = 8'd0; a1 = 8'd0; b0 = 8'd0; b1 = 8'd0;
        #2;
        test_reset();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        test_interleave();
        test_ties();
        test_backpressure();
        test_back_to_back();
        test_order_err();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete, expected finish before 20000");
        $fatal(1, "timeout");
    end

endmodule
